// File: rtl/vga_fb_pkg.sv
// Shared constants and state encoding for the VGA framebuffer arbiter and timing generator.
package vga_fb_pkg;

    localparam int H_WORDS = 20;
    localparam int V_LINES = 240;
    localparam int ADDR_W  = 13;
    localparam int LB_AW   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOST  = 2'd3
    } fb_state_e;

    // 640x480 @ 60 Hz geometry: active, front porch, sync, back porch
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

endpackage

// File: rtl/vga_fb_line_addr.sv
// Combinational framebuffer line -> base word address (line*20) and line range check.
module vga_fb_line_addr #(
    parameter int ADDR_W  = 13,
    parameter int V_LINES = 240
) (
    input  logic [7:0]        i_req_line,
    output logic [ADDR_W-1:0] o_base,
    output logic              o_in_range
);

    logic [ADDR_W-1:0] w_line;

    assign w_line     = ADDR_W'(i_req_line);
    // x20 as x16 + x4, so no multiplier is needed
    assign o_base     = (w_line << 4) + (w_line << 2);
    assign o_in_range = (32'(i_req_line) < 32'(V_LINES));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanline fetch (always wins) vs host writes.
// Optional sticky fetch_overrun output is enabled by defining VGA_FB_OVERRUN_EN.
module vga_fb_arbiter #(
    parameter int H_WORDS = vga_fb_pkg::H_WORDS,
    parameter int V_LINES = vga_fb_pkg::V_LINES,
    parameter int ADDR_W  = vga_fb_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              line_req,
    input  logic [7:0]        req_line,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [4:0]        lb_addr,
    output logic [15:0]       lb_wdata,
`ifdef VGA_FB_OVERRUN_EN
    output logic              fetch_overrun,
`endif
    output logic              fetch_done
);

    import vga_fb_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_FETCH = 2'(FETCH);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);
    localparam logic [1:0] S_HOST  = 2'(HOST);

    logic [1:0]        r_state;
    logic [LB_AW-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_bank;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [15:0]       r_mem_wdata;
    logic              r_lb_we;
    logic [LB_AW-1:0]  r_lb_addr;
    logic              r_fetch_done;

    logic [ADDR_W-1:0] w_base;
    logic              w_in_range;
    logic              w_arb_free;
    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic [LB_AW-1:0]  w_cnt_inc;

    vga_fb_line_addr #(
        .ADDR_W  (ADDR_W),
        .V_LINES (V_LINES)
    ) u_line_addr (
        .i_req_line (req_line),
        .o_base     (w_base),
        .o_in_range (w_in_range)
    );

    assign w_arb_free = (r_state == S_IDLE) || (r_state == S_HOST);
    assign w_start    = w_arb_free && line_req && w_in_range;
    // RESET_N gating keeps wr_ready low for the whole reset, including before the first edge
    assign wr_ready   = RESET_N && w_arb_free && !line_req;
    assign w_accept   = wr_valid && wr_ready;
    assign w_last     = (r_cnt == LB_AW'(H_WORDS - 1));
    assign w_cnt_inc  = r_cnt + LB_AW'(1);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_bank       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_lb_we      <= 1'b0;
            r_lb_addr    <= '0;
            r_fetch_done <= 1'b0;
        end else begin
            // line-buffer side trails the RAM address by the one-cycle read latency
            r_lb_we      <= (r_state == S_FETCH);
            r_lb_addr    <= r_cnt;
            r_fetch_done <= (r_state == S_FETCH) && w_last;
            r_mem_we     <= 1'b0;
            case (r_state)
                S_IDLE, S_HOST: begin
                    if (w_start) begin
                        r_state    <= S_FETCH;
                        r_cnt      <= '0;
                        r_base     <= w_base;
                        r_bank     <= req_line[0];
                        r_mem_addr <= w_base;
                    end else if (w_accept) begin
                        r_state     <= S_HOST;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= wr_addr;
                        r_mem_wdata <= wr_data;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_mem_addr <= r_base + {{(ADDR_W - LB_AW){1'b0}}, w_cnt_inc};
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VGA_FB_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_overrun <= 1'b0;
        end else if (line_req && ((r_state == S_FETCH) || (r_state == S_DRAIN))) begin
            r_overrun <= 1'b1;
        end
    end

    assign fetch_overrun = r_overrun;
`endif

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign lb_we      = r_lb_we;
    assign lb_bank    = r_bank;
    assign lb_addr    = r_lb_addr;
    assign lb_wdata   = mem_rdata;
    assign fetch_done = r_fetch_done;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter with a behavioural RAM and shadow framebuffer.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 13;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              line_req;
    logic [7:0]        req_line;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              lb_we;
    logic              lb_bank;
    logic [4:0]        lb_addr;
    logic [15:0]       lb_wdata;
    logic              fetch_done;
`ifdef VGA_FB_OVERRUN_EN
    logic              fetch_overrun;
`endif

    int checks = 0;
    int errors = 0;
    bit ovr_exp = 1'b0;

    // RAM model contents and the bench's own expectation of the framebuffer
    logic [15:0] ram [8192];
    bit          ram_v [8192];
    logic [15:0] exp_mem [8192];
    bit          exp_v [8192];

    vga_fb_arbiter dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .line_req   (line_req),
        .req_line   (req_line),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .lb_we      (lb_we),
        .lb_bank    (lb_bank),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
`ifdef VGA_FB_OVERRUN_EN
        .fetch_overrun (fetch_overrun),
`endif
        .fetch_done (fetch_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] pat(input int a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    function automatic logic [15:0] exp_word(input int a);
        return exp_v[a] ? exp_mem[a] : pat(a);
    endfunction

    // single-port RAM, read-before-write, one-cycle read latency
    always @(posedge CLK) begin
        if (mem_we) begin
            ram[int'(mem_addr)]   <= mem_wdata;
            ram_v[int'(mem_addr)] <= 1'b1;
        end
        mem_rdata <= ram_v[int'(mem_addr)] ? ram[int'(mem_addr)] : pat(int'(mem_addr));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic note_write(input int a, input logic [15:0] d);
        exp_mem[a] = d;
        exp_v[a]   = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; wr_valid = 1'b1; wr_addr = 13'h0AB; wr_data = 16'h1234;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || lb_we !== 1'b0 ||
                fetch_done !== 1'b0 || lb_addr !== 5'd0 || lb_bank !== 1'b0 || mem_wdata !== 16'd0) begin
                errors++;
                $display("FAIL reset_c%0d got ready=%b we=%b addr=%h lbwe=%b done=%b exp all 0",
                         c, wr_ready, mem_we, mem_addr, lb_we, fetch_done);
            end
            tick();
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_first_ready got %b exp 1", wr_ready);
        end
        note_write(int'(wr_addr), wr_data);
        tick();
        wr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 13'h0AB || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL reset_first_write got we=%b addr=%h data=%h exp 1/0ab/1234", mem_we, mem_addr, mem_wdata);
        end
        tick();
    endtask

    task automatic test_fetch(input int line, input int ovr_at);
        int base;
        base = line * 20;
        line_req = 1'b1; req_line = 8'(line); wr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL fetch%0d_c0_ready got %b exp 0", line, wr_ready);
        end
        tick();
        for (int c = 1; c <= 30; c++) begin
            line_req = (c == ovr_at);
            if (c == ovr_at) req_line = 8'($urandom_range(0, 239));
            @(negedge CLK);
            if (c <= 20) begin
                checks++;
                if (mem_addr !== ADDR_W'(base + c - 1)) begin
                    errors++; $display("FAIL fetch%0d_c%0d_addr got %0d exp %0d", line, c, mem_addr, base + c - 1);
                end
            end
            checks++;
            if (mem_we !== 1'b0) begin
                errors++; $display("FAIL fetch%0d_c%0d_memwe got %b exp 0", line, c, mem_we);
            end
            checks++;
            if (lb_we !== 1'((c >= 2) && (c <= 21))) begin
                errors++; $display("FAIL fetch%0d_c%0d_lbwe got %b exp %b", line, c, lb_we, (c >= 2) && (c <= 21));
            end
            if (c >= 2 && c <= 21) begin
                checks++;
                if (lb_addr !== 5'(c - 2) || lb_bank !== line[0] || lb_wdata !== exp_word(base + c - 2)) begin
                    errors++;
                    $display("FAIL fetch%0d_c%0d_lb got addr=%0d bank=%b data=%h exp %0d/%b/%h",
                             line, c, lb_addr, lb_bank, lb_wdata, c - 2, line[0], exp_word(base + c - 2));
                end
            end
            checks++;
            if (fetch_done !== 1'(c == 21)) begin
                errors++; $display("FAIL fetch%0d_c%0d_done got %b exp %b", line, c, fetch_done, c == 21);
            end
            checks++;
            if (wr_ready !== 1'(c >= 22)) begin
                errors++; $display("FAIL fetch%0d_c%0d_ready got %b exp %b", line, c, wr_ready, c >= 22);
            end
`ifdef VGA_FB_OVERRUN_EN
            checks++;
            if (fetch_overrun !== ovr_exp) begin
                errors++; $display("FAIL fetch%0d_c%0d_overrun got %b exp %b", line, c, fetch_overrun, ovr_exp);
            end
`endif
            if (c == ovr_at) ovr_exp = 1'b1;
            tick();
        end
        line_req = 1'b0;
    endtask

    task automatic test_collision();
        int line;
        line = $urandom_range(0, 239);
        line_req = 1'b1; req_line = 8'(line);
        wr_valid = 1'b1; wr_addr = 13'h100; wr_data = 16'hA5A5;
        for (int c = 0; c <= 23; c++) begin
            @(negedge CLK);
            if (c <= 22) begin
                checks++;
                if (wr_ready !== 1'(c == 22)) begin
                    errors++; $display("FAIL collide_c%0d_ready got %b exp %b", c, wr_ready, c == 22);
                end
            end
            if (c == 22) note_write(32'h100, 16'hA5A5);
            checks++;
            if (mem_we !== 1'(c == 23) || (c == 23 && (mem_addr !== 13'h100 || mem_wdata !== 16'hA5A5))) begin
                errors++; $display("FAIL collide_c%0d_write got we=%b addr=%h data=%h", c, mem_we, mem_addr, mem_wdata);
            end
            tick();
            line_req = 1'b0;
            if (c == 22) wr_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_back_to_back(input int n, input int lr_at);
        int sent, cyc, line, exp_cyc;
        bit pend, acc, exp_ready;
        logic [ADDR_W-1:0] pa;
        logic [15:0] pd;
        logic [15:0] d [8];
        sent = 0; cyc = 0; pend = 1'b0; pa = '0; pd = '0;
        line = $urandom_range(0, 239);
        for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
        while ((sent < n || pend) && cyc < 200) begin
            wr_valid = (sent < n);
            wr_addr  = ADDR_W'(sent);
            wr_data  = d[sent % 8];
            line_req = (cyc == lr_at);
            req_line = 8'(line);
            @(negedge CLK);
            exp_ready = !(lr_at >= 0 && cyc >= lr_at && cyc <= lr_at + 21);
            checks++;
            if (wr_ready !== exp_ready) begin
                errors++; $display("FAIL burst_lr%0d_c%0d_ready got %b exp %b", lr_at, cyc, wr_ready, exp_ready);
            end
            checks++;
            if (mem_we !== pend || (pend && (mem_addr !== pa || mem_wdata !== pd))) begin
                errors++;
                $display("FAIL burst_lr%0d_c%0d_write got we=%b addr=%h data=%h exp %b/%h/%h",
                         lr_at, cyc, mem_we, mem_addr, mem_wdata, pend, pa, pd);
            end
            if (lr_at >= 0) begin
                checks++;
                if (fetch_done !== 1'(cyc == lr_at + 21)) begin
                    errors++; $display("FAIL burst_lr%0d_c%0d_done got %b exp %b", lr_at, cyc, fetch_done, cyc == lr_at + 21);
                end
            end
            acc = wr_valid && exp_ready;
            if (acc) begin
                note_write(sent, wr_data);
                pa = wr_addr; pd = wr_data;
                sent++;
            end
            pend = acc;
            tick();
            cyc++;
        end
        wr_valid = 1'b0; line_req = 1'b0;
        exp_cyc = n + 1 + ((lr_at >= 0 && lr_at < n) ? 22 : 0);
        checks++;
        if (cyc !== exp_cyc) begin
            errors++; $display("FAIL burst_lr%0d_length got %0d exp %0d", lr_at, cyc, exp_cyc);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_out_of_range(input int line);
        line_req = 1'b1; req_line = 8'(line); wr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL oor%0d_c0_ready got %b exp 0", line, wr_ready);
        end
        tick();
        line_req = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge CLK);
            checks++;
            if (lb_we !== 1'b0 || fetch_done !== 1'b0 || wr_ready !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL oor%0d_c%0d got lbwe=%b done=%b ready=%b we=%b exp 0/0/1/0",
                         line, c, lb_we, fetch_done, wr_ready, mem_we);
            end
            tick();
        end
    endtask

    task automatic host_write(input int a, input logic [15:0] dat);
        wr_valid = 1'b1; wr_addr = ADDR_W'(a); wr_data = dat;
        @(negedge CLK);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL hw_%0d_ready got %b exp 1", a, wr_ready);
        end
        note_write(a, dat);
        tick();
        wr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(a) || mem_wdata !== dat) begin
            errors++; $display("FAIL hw_%0d_write got we=%b addr=%h data=%h exp 1/%h/%h", a, mem_we, mem_addr, mem_wdata, a, dat);
        end
        tick();
    endtask

    task automatic test_random();
        int line;
        for (int it = 0; it < 10; it++) begin
            line = $urandom_range(0, 239);
            for (int k = 0; k < 3; k++) host_write(line * 20 + $urandom_range(0, 19), 16'($urandom));
            test_fetch(line, -1);
        end
    endtask

    task automatic test_reset_mid_fetch();
        line_req = 1'b1; req_line = 8'($urandom_range(0, 239)); wr_valid = 1'b0;
        tick();
        line_req = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        RESET_N = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready got %b exp 0", wr_ready);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (lb_we !== 1'b0 || fetch_done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || lb_addr !== 5'd0) begin
                errors++;
                $display("FAIL rstmid_c%0d got lbwe=%b done=%b we=%b addr=%h lbaddr=%0d exp zeros",
                         c, lb_we, fetch_done, mem_we, mem_addr, lb_addr);
            end
`ifdef VGA_FB_OVERRUN_EN
            checks++;
            if (fetch_overrun !== 1'b0) begin
                errors++; $display("FAIL rstmid_c%0d_overrun got %b exp 0", c, fetch_overrun);
            end
`endif
            tick();
        end
        RESET_N = 1'b1;
        ovr_exp = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            checks++;
            if (lb_we !== 1'b0 || fetch_done !== 1'b0 || wr_ready !== 1'b1) begin
                errors++; $display("FAIL rstmid_after_c%0d got lbwe=%b done=%b ready=%b exp 0/0/1", c, lb_we, fetch_done, wr_ready);
            end
            tick();
        end
    endtask

    initial begin
        line_req = 1'b0; req_line = 8'd0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; RESET_N = 1'b0;
        test_reset();
        test_fetch(3, -1);
        test_fetch(239, -1);
        test_fetch(0, -1);
        test_collision();
        test_back_to_back(8, -1);
        test_back_to_back(8, 3);
        test_out_of_range(240);
        test_out_of_range($urandom_range(241, 255));
        test_fetch($urandom_range(0, 239), 10);
        test_random();
        test_reset_mid_fetch();
        test_fetch($urandom_range(0, 239), -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbiter and sequencer for the single-port framebuffer RAM behind the 640x480 VGA output. Shares the RAM between the scanline fetch engine, which has a hard deadline, and a host write port with a valid/ready handshake. Sits in the 25 MHz pixel-clock domain, between the VGA timing generator and the framebuffer and line-buffer BRAMs. The framebuffer is 320x240, 1 bpp, packed 16 pixels per word, and is line-doubled on output.

## Interface
Parameters:
- H_WORDS, 20: words per framebuffer line (320/16).
- V_LINES, 240: framebuffer lines.
- ADDR_W, 13: RAM word address width (4800 words).

Ports:
- CLK  in  1  pixel clock (25 MHz). One clock; reset is synchronous and active-low.
- RESET_N  in  1  synchronous, active-low reset.
- line_req  in  1  one-cycle pulse from the timing generator at the start of h-blank.
- req_line  in  8  framebuffer line to fetch; sampled only with line_req.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  host word address.
- wr_data  in  16  host pixel word.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  16  RAM write data (registered).
- mem_rdata  in  16  RAM read data; 1-cycle latency.
- lb_we  out  1  line-buffer write strobe.
- lb_bank  out  1  line-buffer bank; equals req_line[0] of the current fetch.
- lb_addr  out  5  line-buffer word index, 0..H_WORDS-1.
- lb_wdata  out  16  line-buffer data; equals mem_rdata.
- fetch_done  out  1  one-cycle pulse when the last word is written to the line buffer.

## Operation
- States:
  - IDLE: no RAM access.
  - FETCH: one read per cycle, H_WORDS cycles.
  - DRAIN: last read data returns.
  - HOST: write issued this cycle.
- IDLE/HOST + line_req with req_line < V_LINES -> FETCH.
  - Latch base = req_line*20, computed as (req_line<<4)+(req_line<<2) in ADDR_W bits.
  - Latch bank = req_line[0].
- IDLE/HOST + line_req with req_line >= V_LINES: request dropped, no fetch, no fetch_done.
- FETCH issues base+0 .. base+H_WORDS-1 on consecutive cycles, then goes to DRAIN. DRAIN goes to IDLE.
- Priority: fetch always wins. wr_ready = (state is IDLE or HOST) && !line_req.
- Accepted host write -> HOST next cycle with mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Back-to-back accepts give 1 write/cycle.
  - With no accept, HOST -> IDLE.
- line_req during FETCH/DRAIN is an overrun: ignored, the current fetch completes unchanged.
- mem_we is 0 in all states except HOST. Reads have no enable; mem_addr is meaningful only in FETCH.
- Reset values: state IDLE, wr_ready 0 during reset, mem_addr 0, mem_we 0, mem_wdata 0, lb_we 0, lb_bank 0, lb_addr 0, lb_wdata follows mem_rdata, fetch_done 0.
- Reset mid-fetch aborts the fetch with no fetch_done. The line buffer may hold partial data.

## Timing
- Cycle 0: line_req sampled.
- Cycles 1..20: mem_addr = base+0..19.
- Cycles 2..21: lb_we=1, lb_addr=0..19, lb_wdata=mem_rdata.
- Cycle 21: fetch_done=1 (DRAIN).
- Cycle 22: IDLE; wr_ready may be high.
- The fetch takes 22 cycles, well within the 160-cycle h-blank.
- Host write accepted in cycle t reaches the RAM in cycle t+1.
- Worst-case host stall is 22 cycles per line_req.

## Configuration
- VGA_FB_OVERRUN_EN defined:
  - Adds output fetch_overrun (1 bit), sticky.
  - Set the cycle after any line_req seen in FETCH or DRAIN.
  - Cleared only by reset.
- Not defined: the port is absent and overruns are silently ignored.

## Structure
- Shared package vga_fb_pkg holds:
  - H_WORDS, V_LINES, ADDR_W, LB_AW (5).
  - State enum {IDLE, FETCH, DRAIN, HOST}.
  - Screen geometry constants shared with the timing generator (640/16/96/48, 480/10/2/33).
- One sub-module, vga_fb_line_addr: combinational req_line -> base (x20) plus the range check, reused by the timing generator's debug path.
- Everything else stays flat: the FSM, word counter (0..19), and output registers.

## Test plan
- Reset with wr_valid=1 held -> wr_ready=0, mem_we=0 throughout reset. First accept occurs the cycle after RESET_N rises.
- line_req, req_line=3 -> mem_addr 60..79 in cycles 1..20; lb_addr 0..19, lb_bank=1 in cycles 2..21; fetch_done in cycle 21.
- line_req and wr_valid in the same cycle, wr_addr=0x100, wr_data=0xA5A5 -> wr_ready=0 until cycle 22; write reaches the RAM in cycle 23.
- 8 back-to-back host writes, addresses 0..7, in IDLE -> mem_we high 8 consecutive cycles with matching addr/data. A line_req mid-burst stalls the burst for 22 cycles, then it resumes.
- req_line=239 -> last address 4799. req_line=240 -> no RAM reads, no fetch_done, wr_ready stays high.
- Second line_req at cycle 10 of a fetch -> first fetch completes unchanged, no second fetch. With VGA_FB_OVERRUN_EN, fetch_overrun=1 from cycle 11 until reset.
